ps2_mouse_init_ctrl: RTL
========================

Name: ps2_mouse_init_ctrl

Overview:
- Sequences the shared PS/2 transceiver (ps2_rxtx) through the full mouse bring-up: reset, self-test check, sample rate, resolution, enable streaming.
- Checks every acknowledge, handles resend requests, timeouts and bounded retries.
- After bring-up it forwards raw stream bytes to the packet assembler.
- Sits between ps2_rxtx and the mouse packet decoder and replaces the decoder's one-shot F4 write.

Parameters:
- SAMPLE_RATE, 8'd100, argument sent after F3.
- RESOLUTION, 8'd3, argument sent after E8.
- HOLDOFF_CYCLES, 200000, idle cycles before the first command after reset, reinit or restart. Must cover one in-flight PS/2 frame.
- ACK_TIMEOUT_CYCLES, 2000000, limit for WAIT_TX, WAIT_ACK and WAIT_ID.
- BAT_TIMEOUT_CYCLES, 75000000, limit for WAIT_BAT (self-test).
- MAX_RETRIES, 3, failures tolerated before FAIL.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- reinit  in  1  single-cycle pulse; restarts bring-up from any state
- ps2_wr  out  1  one-cycle write strobe to transceiver
- ps2_din  out  8  byte to transmit
- ps2_dout  in  8  received byte, valid with ps2_rx_done_tick
- ps2_rx_done_tick  in  1  byte received
- ps2_tx_done_tick  in  1  transmit finished
- stream_byte  out  8  forwarded data byte
- stream_valid  out  1  one-cycle strobe qualifying stream_byte
- ready  out  1  high only in STREAM
- init_fail  out  1  high only in FAIL
- dev_id  out  8  ID byte captured after AA
- retry_cnt  out  2  failures since last successful bring-up

Behaviour:
- Reset values: state HOLDOFF, step 0, timer 0, retry_cnt 0, ps2_wr 0, ps2_din 8'hFF, stream_byte 0, stream_valid 0, ready 0, init_fail 0, dev_id 0.
- Command list by step 0..5: FF, F3, SAMPLE_RATE, E8, RESOLUTION, F4. ps2_din is registered and always equals cmd[step].
- Timer clears on every state entry and increments each cycle in wait states. A timeout fires on the cycle timer == limit-1.
- States and transitions:
  - HOLDOFF: after HOLDOFF_CYCLES go to SEND.
  - SEND: ps2_wr=1 for exactly this one cycle, then go to WAIT_TX.
  - WAIT_TX: on ps2_tx_done_tick go to WAIT_ACK. rx ticks here are ignored. Timeout -> failure(restart).
  - WAIT_ACK, on rx byte:
    - FA and step==0: go to WAIT_BAT.
    - FA and step 1..4: step+1, go to SEND.
    - FA and step==5: go to STREAM and clear retry_cnt.
    - FE: failure(resend).
    - any other byte, or timeout: failure(restart).
  - WAIT_BAT: AA goes to WAIT_ID. Any other byte (e.g. FC) or timeout -> failure(restart).
  - WAIT_ID: any byte is latched into dev_id, then step=1, go to SEND. Timeout -> failure(restart).
  - STREAM: each ps2_rx_done_tick registers ps2_dout into stream_byte and pulses stream_valid the next cycle (latency 1). Byte content is not checked. Stays in STREAM until reinit or reset.
  - FAIL: holds until reinit or reset.
- Failure handling:
  - If retry_cnt == MAX_RETRIES-1, go to FAIL.
  - Otherwise retry_cnt+1, then:
    - resend: same step, go to SEND directly, no holdoff.
    - restart: step 0, go to HOLDOFF.
- reinit has priority over every event in the same cycle. It sets step 0, retry_cnt 0, state HOLDOFF, ready 0, init_fail 0. A concurrent rx or tx tick is discarded.
- Async reset mid-transfer returns all registers to reset values immediately. The HOLDOFF period absorbs any transceiver frame still in flight.
- ps2_wr is never asserted outside SEND.
- stream_valid is never asserted outside STREAM, except the single delayed pulse for a byte accepted on the last STREAM cycle before reinit. That pulse is suppressed: reinit clears stream_valid.

Test Plan (HOLDOFF_CYCLES=10, ACK_TIMEOUT_CYCLES=50, BAT_TIMEOUT_CYCLES=100, MAX_RETRIES=3):
- Nominal bring-up: model replies FA, AA, 00, then FA to each of F3, 64, E8, 03, F4 -> ps2_din sequence FF, F3, 64, E8, 03, F4. Six one-cycle ps2_wr pulses. ready=1. dev_id=00. retry_cnt=0.
- Resend: reply FE to the F3 argument byte 64 once, then FA -> 64 is re-sent with no holdoff, retry_cnt=1, then ready=1 and retry_cnt=0.
- Self-test failure: reply FC instead of AA on all three attempts -> three FF sends, each preceded by holdoff. init_fail=1 after the third. ps2_wr stays 0 afterwards.
- Timeout: no tx_done after the first SEND -> restart at cycle 50. Three misses give init_fail=1. Then a reinit pulse -> init_fail=0 and FF re-sent after 10 cycles.
- Stream forwarding: in STREAM, inject 08, 05, FD -> stream_valid pulses three times, one cycle after each rx tick, with matching stream_byte.
- Priority and reset: reinit in the same cycle as rx FA during WAIT_ACK -> HOLDOFF, step 0, FA discarded. Async reset during WAIT_TX -> ps2_wr=0 and ps2_din=FF immediately.

Source files
------------

// File: rtl/ps2_mouse_init_if.sv
// Transceiver and stream-side signals of the PS/2 mouse bring-up controller.
// master = controller side, slave = transceiver / packet assembler side.
interface ps2_mouse_init_if;
   logic       ps2_wr;
   logic [7:0] ps2_din;
   logic [7:0] ps2_dout;
   logic       ps2_rx_done_tick;
   logic       ps2_tx_done_tick;
   logic [7:0] stream_byte;
   logic       stream_valid;

   modport master (
      output ps2_wr, ps2_din, stream_byte, stream_valid,
      input  ps2_dout, ps2_rx_done_tick, ps2_tx_done_tick
   );

   modport slave (
      input  ps2_wr, ps2_din, stream_byte, stream_valid,
      output ps2_dout, ps2_rx_done_tick, ps2_tx_done_tick
   );
endinterface

// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse bring-up sequencer (FF, F3 rate, E8 res, F4) with ack checking and bounded retries.
// Stream bytes forwarded with 1-cycle latency; no backpressure, the transceiver ticks are single-cycle.
module ps2_mouse_init_ctrl #(
   parameter logic [7:0]  SAMPLE_RATE        = 8'd100,
   parameter logic [7:0]  RESOLUTION         = 8'd3,
   parameter int unsigned HOLDOFF_CYCLES     = 200000,
   parameter int unsigned ACK_TIMEOUT_CYCLES = 2000000,
   parameter int unsigned BAT_TIMEOUT_CYCLES = 75000000,
   parameter int unsigned MAX_RETRIES        = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             reinit,
   ps2_mouse_init_if.master bus,
   output logic             ready,
   output logic             init_fail,
   output logic [7:0]       dev_id,
   output logic [1:0]       retry_cnt
);

   localparam logic [31:0] HOLD_LAST  = 32'(HOLDOFF_CYCLES - 1);
   localparam logic [31:0] ACK_LAST   = 32'(ACK_TIMEOUT_CYCLES - 1);
   localparam logic [31:0] BAT_LAST   = 32'(BAT_TIMEOUT_CYCLES - 1);
   localparam logic [1:0]  RETRY_LAST = 2'(MAX_RETRIES - 1);

   typedef enum logic [2:0] {
      HOLDOFF, SEND, WAIT_TX, WAIT_ACK, WAIT_BAT, WAIT_ID, STREAM, FAIL
   } state_t;

   state_t      state, state_next;
   logic [2:0]  step, step_next;
   logic [31:0] timer, timer_next;
   logic [1:0]  retry_next;
   logic [7:0]  dev_id_next;
   logic        fail_ev, fail_resend;
   logic        rx, tx;
   logic [7:0]  stream_byte_q;
   logic        stream_valid_q;
   logic [7:0]  din_q;

   assign rx = bus.ps2_rx_done_tick;
   assign tx = bus.ps2_tx_done_tick;

   function automatic logic [7:0] cmd_byte(input logic [2:0] s);
      case (s)
         3'd1:    cmd_byte = 8'hF3;
         3'd2:    cmd_byte = SAMPLE_RATE;
         3'd3:    cmd_byte = 8'hE8;
         3'd4:    cmd_byte = RESOLUTION;
         3'd5:    cmd_byte = 8'hF4;
         default: cmd_byte = 8'hFF;
      endcase
   endfunction

   always_comb begin
      state_next  = state;
      step_next   = step;
      retry_next  = retry_cnt;
      dev_id_next = dev_id;
      fail_ev     = 1'b0;
      fail_resend = 1'b0;

      case (state)
         HOLDOFF: if (timer == HOLD_LAST) state_next = SEND;
         SEND:    state_next = WAIT_TX;
         WAIT_TX: begin
            if (tx)                    state_next = WAIT_ACK;
            else if (timer == ACK_LAST) fail_ev    = 1'b1;
         end
         WAIT_ACK: begin
            if (rx) begin
               if (bus.ps2_dout == 8'hFA) begin
                  if (step == 3'd0) begin
                     state_next = WAIT_BAT;
                  end else if (step == 3'd5) begin
                     state_next = STREAM;
                     retry_next = 2'd0;
                  end else begin
                     step_next  = step + 3'd1;
                     state_next = SEND;
                  end
               end else begin
                  fail_ev     = 1'b1;
                  fail_resend = (bus.ps2_dout == 8'hFE);
               end
            end else if (timer == ACK_LAST) begin
               fail_ev = 1'b1;
            end
         end
         WAIT_BAT: begin
            if (rx) begin
               if (bus.ps2_dout == 8'hAA) state_next = WAIT_ID;
               else                      fail_ev    = 1'b1;
            end else if (timer == BAT_LAST) begin
               fail_ev = 1'b1;
            end
         end
         WAIT_ID: begin
            if (rx) begin
               dev_id_next = bus.ps2_dout;
               step_next   = 3'd1;
               state_next  = SEND;
            end else if (timer == ACK_LAST) begin
               fail_ev = 1'b1;
            end
         end
         default: ;
      endcase

      if (fail_ev) begin
         if (retry_cnt == RETRY_LAST) begin
            state_next = FAIL;
         end else begin
            retry_next = retry_cnt + 2'd1;
            if (fail_resend) begin
               state_next = SEND;
            end else begin
               step_next  = 3'd0;
               state_next = HOLDOFF;
            end
         end
      end

      // reinit overrides whatever the tick handling above decided
      if (reinit) begin
         state_next  = HOLDOFF;
         step_next   = 3'd0;
         retry_next  = 2'd0;
         dev_id_next = dev_id;
      end

      if (reinit || (state_next != state))
         timer_next = 32'd0;
      else if (state == HOLDOFF || state == WAIT_TX || state == WAIT_ACK ||
               state == WAIT_BAT || state == WAIT_ID)
         timer_next = timer + 32'd1;
      else
         timer_next = 32'd0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= HOLDOFF;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step           <= 3'd0;
         timer          <= 32'd0;
         retry_cnt      <= 2'd0;
         dev_id         <= 8'h00;
         din_q          <= 8'hFF;
         stream_byte_q  <= 8'h00;
         stream_valid_q <= 1'b0;
      end else begin
         step           <= step_next;
         timer          <= timer_next;
         retry_cnt      <= retry_next;
         dev_id         <= dev_id_next;
         din_q          <= cmd_byte(step_next);
         stream_valid_q <= (state == STREAM) && rx && !reinit;
         if ((state == STREAM) && rx && !reinit)
            stream_byte_q <= bus.ps2_dout;
      end
   end

   assign bus.ps2_wr       = (state == SEND);
   assign bus.ps2_din      = din_q;
   assign bus.stream_byte  = stream_byte_q;
   assign bus.stream_valid = stream_valid_q;
   assign ready            = (state == STREAM);
   assign init_fail        = (state == FAIL);

endmodule
